icache_refill_ctrl: RTL

Refill controller between the fetch-stage L1 instruction cache and the lower memory hierarchy. It accepts the cache miss indication and miss address from fetch stage 1 and issues one block request to memory. It assembles the returned multi-beat data into a full cache block and writes it back into the L1 I-cache through the cache's write port (`wrEnable`/`wrAddr`/`instBlock`). One refill is outstanding at a time.

---
 rtl/icache_refill_ctrl_pkg.sv | 39 +++
 rtl/icache_refill_ctrl_assembler.sv | 50 +++++
 rtl/icache_refill_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared fetch refill types, derived constants and block-align helper
package icache_refill_ctrl_pkg;

  // Refill sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_FILL = 2'd3
  } refill_state_e;

  // Default geometry, matching SIZE_PC / CACHE_WIDTH of the fetch stage
  localparam int DEF_PC_W    = 32;
  localparam int DEF_BLOCK_W = 256;
  localparam int DEF_BUS_W   = 64;
  localparam int DEF_CNT_W   = 16;

  // Widest address the align helper handles
  localparam int MAX_PC_W = 64;

  // Number of return beats that make up one cache block
  function automatic int calc_beats(input int block_w, input int bus_w);
    return block_w / bus_w;
  endfunction

  // Number of byte-offset bits inside one cache block
  function automatic int calc_off_bits(input int block_w);
    return $clog2(block_w / 8);
  endfunction

  // Clear the byte-offset bits so the address points at the start of its block
  function automatic logic [MAX_PC_W-1:0] block_align(input logic [MAX_PC_W-1:0] addr,
                                                      input int off_bits);
    logic [MAX_PC_W-1:0] mask;
    mask = ~{MAX_PC_W{1'b0}} << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_assembler.sv
// rtl/icache_refill_ctrl_assembler.sv - collects BUS_W return beats into one cache block
module refill_beat_assembler
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int BUS_W   = DEF_BUS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               beat_valid_i,
  input  logic [BUS_W-1:0]   beat_data_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic               last_beat_o
);

  localparam int BEATS = calc_beats(BLOCK_W, BUS_W);
  localparam int BCNT_W = $clog2(BEATS);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  logic [BCNT_W-1:0]  cnt_q, cnt_d;
  logic [BLOCK_W-1:0] block_q, block_d;

  // Insert each valid beat at its slot (beat 0 = least significant) and advance the counter
  always_comb begin
    cnt_d   = cnt_q;
    block_d = block_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (beat_valid_i) begin
      block_d[cnt_q*BUS_W +: BUS_W] = beat_data_i;
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + BCNT_W'(1);
    end
  end

  // Beat counter and block storage
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign block_o     = block_q;
  assign last_beat_o = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - L1 I-cache miss refill sequencer, one refill outstanding
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int BUS_W   = DEF_BUS_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_i,
  input  logic [PC_W-1:0]    missAddr_i,
  output logic               memReq_o,
  output logic [PC_W-1:0]    memAddr_o,
  input  logic               memGnt_i,
  input  logic               memValid_i,
  input  logic [BUS_W-1:0]   memData_i,
  output logic               wrEnable_o,
  output logic [PC_W-1:0]    wrAddr_o,
  output logic [BLOCK_W-1:0] instBlock_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   refillCount_o
);

  localparam int OFF_BITS = calc_off_bits(BLOCK_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  refill_state_e    state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [PC_W-1:0]  mem_addr_q, mem_addr_d;
  logic             wr_en_q, wr_en_d;
  logic [PC_W-1:0]  wr_addr_q, wr_addr_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] refill_cnt_q, refill_cnt_d;

  logic               asm_clear;
  logic               asm_valid;
  logic               asm_last;
  logic [BLOCK_W-1:0] asm_block;

  refill_beat_assembler #(
    .BLOCK_W (BLOCK_W),
    .BUS_W   (BUS_W)
  ) u_assembler (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (asm_clear),
    .beat_valid_i (asm_valid),
    .beat_data_i  (memData_i),
    .block_o      (asm_block),
    .last_beat_o  (asm_last)
  );

  // Next-state and next-output decode; outputs are registered so the interface is pure Moore
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    refill_cnt_d = refill_cnt_q;
    asm_clear    = 1'b0;
    asm_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_i) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = PC_W'(block_align(MAX_PC_W'(missAddr_i), OFF_BITS));
        end
      end
      ST_REQ: begin
        // A valid arriving with the grant is not a real beat and is dropped
        if (memGnt_i) begin
          state_d   = ST_RECV;
          mem_req_d = 1'b0;
          asm_clear = 1'b1;
        end
      end
      ST_RECV: begin
        if (memValid_i) begin
          asm_valid = 1'b1;
          if (asm_last) begin
            state_d   = ST_FILL;
            wr_en_d   = 1'b1;
            wr_addr_d = mem_addr_q;
            if (refill_cnt_q != CNT_MAX) begin
              refill_cnt_d = refill_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_FILL: begin
        // The cache line is written this cycle; a miss seen in the next IDLE cycle is genuine
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any refill in flight without writing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      busy_q       <= 1'b0;
      refill_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      busy_q       <= busy_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

  assign memReq_o      = mem_req_q;
  assign memAddr_o     = mem_addr_q;
  assign wrEnable_o    = wr_en_q;
  assign wrAddr_o      = wr_addr_q;
  assign instBlock_o   = asm_block;
  assign busy_o        = busy_q;
  assign refillCount_o = refill_cnt_q;

endmodule
